imem_loader: RTL and testbench

- Write-side master for the 64-word instruction memory: receives a program as a byte stream and assembles little-endian 32-bit words.
- Drives the memory's address, write-data and write-enable inputs, one word at a time.
- Holds the CPU in stall while loading and reports completion or a length error.
- Sits between the host/UART byte interface and the instruction memory write port.

---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_word_packer.sv | 38 +++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Word layout is little-endian: byte k of the stream lands in bits [8k+7:8k].
package imem_pkg;

  localparam int IMEM_DEPTH     = 64;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2
  } loader_state_t;

  typedef logic [31:0] imem_word_t;

endpackage

// File: rtl/imem_loader_if.sv
// Control, byte-stream and memory-write bundle of the loader.
// The master side is the loader itself; the slave side is the host/memory environment.
interface imem_loader_if #(parameter int CNT_W = 7);
  import imem_pkg::*;

  logic             start;
  logic [CNT_W-1:0] num_words;
  logic             abort;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic [31:0]      mem_addr;
  imem_word_t       mem_wdata;
  logic             mem_we;
  logic             cpu_stall;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, num_words, abort, in_valid, in_data,
    output in_ready, mem_addr, mem_wdata, mem_we, cpu_stall, busy, done, err
  );

  modport slave (
    output start, num_words, abort, in_valid, in_data,
    input  in_ready, mem_addr, mem_wdata, mem_we, cpu_stall, busy, done, err
  );

endinterface

// File: rtl/imem_word_packer.sv
// Byte shift-in register: places each accepted byte in its little-endian lane
// and flags the shift that completes a 32-bit word.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       shift_en,
  input  logic [7:0] byte_in,
  output imem_word_t word_next,
  output logic       word_full
);

  logic [1:0] byte_cnt_r;
  imem_word_t word_r;

  // Word as it looks with the incoming byte merged into its lane
  always_comb begin
    word_next = word_r;
    word_next[{byte_cnt_r, 3'b000} +: 8] = byte_in;
    word_full = shift_en && (byte_cnt_r == 2'd3);
  end

  // Byte counter and partial word; clear drops any partial word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_r <= 2'd0;
      word_r     <= 32'h0000_0000;
    end else if (clear) begin
      byte_cnt_r <= 2'd0;
    end else if (shift_en) begin
      word_r     <= word_next;
      byte_cnt_r <= byte_cnt_r + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a byte stream into words, writes them
// one per WRITE cycle from BASE_ADDR upward and stalls the CPU while loading.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.master bus
);

  loader_state_t    state_r;
  logic [CNT_W-1:0] num_words_r;
  logic [CNT_W-1:0] word_cnt_r;
  logic [CNT_W-1:0] word_cnt_inc_s;
  logic [31:0]      mem_addr_r;
  imem_word_t       mem_wdata_r;
  logic             mem_we_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;

  logic             len_ok_s;
  logic             shift_en_s;
  logic             pack_clear_s;
  logic             word_full_s;
  imem_word_t       word_next_s;
  logic [31:0]      word_addr_s;

  // Handshake qualification, packer control and address generation
  always_comb begin
    len_ok_s       = (bus.num_words >= CNT_W'(1)) && (bus.num_words <= CNT_W'(DEPTH));
    shift_en_s     = (state_r == RECV) && bus.in_valid && in_ready_r && !bus.abort;
    pack_clear_s   = ((state_r == IDLE) && bus.start) || (state_r == WRITE) ||
                     ((state_r == RECV) && bus.abort);
    word_cnt_inc_s = word_cnt_r + CNT_W'(1);
    word_addr_s    = BASE_ADDR + (32'(word_cnt_r) * 32'(BYTES_PER_WORD));
  end

  imem_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pack_clear_s),
    .shift_en  (shift_en_s),
    .byte_in   (bus.in_data),
    .word_next (word_next_s),
    .word_full (word_full_s)
  );

  // Load sequencer with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      num_words_r <= {CNT_W{1'b0}};
      word_cnt_r  <= {CNT_W{1'b0}};
      mem_addr_r  <= BASE_ADDR;
      mem_wdata_r <= 32'h0000_0000;
      mem_we_r    <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_we_r   <= 1'b0;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          if (bus.start && len_ok_s) begin
            num_words_r <= bus.num_words;
            word_cnt_r  <= {CNT_W{1'b0}};
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= RECV;
          end else if (bus.start) begin
            err_r  <= 1'b1;
            done_r <= 1'b0;
          end
        end
        RECV: begin
          mem_we_r <= 1'b0;
          if (bus.abort) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else if (word_full_s) begin
            // Word complete: present it together with the strobe next cycle
            mem_we_r    <= 1'b1;
            mem_addr_r  <= word_addr_s;
            mem_wdata_r <= word_next_s;
            in_ready_r  <= 1'b0;
            state_r     <= WRITE;
          end
        end
        WRITE: begin
          mem_we_r   <= 1'b0;
          word_cnt_r <= word_cnt_inc_s;
          if (bus.abort) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (word_cnt_inc_s == num_words_r) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= RECV;
          end
        end
        default: begin
          mem_we_r   <= 1'b0;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.cpu_stall = busy_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a word-level model of the program image
// and load outcome is compared against the write strobes seen on the memory port.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int DEPTH = 64;
  localparam int CNT_W = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.CNT_W(CNT_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          we_count = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] seen_mem  [DEPTH];
  logic [7:0]  stim      [DEPTH*4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Capture every write the memory would see
  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      check_eq("addr_in_range", {bus.mem_addr[31:8], bus.mem_addr[1:0]}, 32'h0);
      seen_mem[bus.mem_addr[7:2]] = bus.mem_wdata;
      we_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] le_word(input int w);
    return 32'(stim[4*w]) + (32'(stim[4*w+1]) << 8) +
           (32'(stim[4*w+2]) << 16) + (32'(stim[4*w+3]) << 24);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit got;
    got = 1'b0;
    if (gap) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int c = 0; c < 20 && !got; c++) begin
      got = bus.in_ready;
      tick();
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    if (!got) check_eq("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input int n, input int abort_after, input bit gap, input int restart_at);
    int base_we;
    int acc;
    logic [31:0] exp_w;
    base_we = we_count;
    acc = 0;
    bus.start = 1'b1;
    bus.num_words = CNT_W'(n);
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_eq("start_busy", 32'(bus.busy), 32'd1);
    check_eq("start_stall", 32'(bus.cpu_stall), 32'd1);
    check_eq("start_done", 32'(bus.done), 32'd0);
    check_eq("start_err", 32'(bus.err), 32'd0);
    for (int w = 0; w < n; w++) begin
      exp_w = le_word(w);
      for (int k = 0; k < 4; k++) begin
        if (w == restart_at && k == 0) begin
          bus.start = 1'b1;
          bus.num_words = CNT_W'(3);
        end
        send_byte(stim[4*w+k], gap && (k != 0));
        acc++;
        if (abort_after == acc && k != 3) begin
          bus.abort = 1'b1;
          tick();
          bus.abort = 1'b0;
          check_eq("abort_busy", 32'(bus.busy), 32'd0);
          check_eq("abort_done", 32'(bus.done), 32'd0);
          check_eq("abort_writes", 32'(we_count - base_we), 32'(acc / 4));
          return;
        end
      end
      check_eq("write_we", 32'(bus.mem_we), 32'd1);
      check_eq("write_ready", 32'(bus.in_ready), 32'd0);
      check_eq("write_addr", bus.mem_addr, 32'(4 * w));
      check_eq("write_data", bus.mem_wdata, exp_w);
      model_mem[w] = exp_w;
      if (abort_after == acc) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_eq("abortw_busy", 32'(bus.busy), 32'd0);
        check_eq("abortw_done", 32'(bus.done), 32'd0);
        check_eq("abortw_writes", 32'(we_count - base_we), 32'(w + 1));
        return;
      end
      if (w == n - 1) begin
        bus.in_valid = 1'b1;
        bus.in_data = 8'($urandom);
        tick();
        bus.in_valid = 1'b0;
        check_eq("end_done", 32'(bus.done), 32'd1);
        check_eq("end_busy", 32'(bus.busy), 32'd0);
        check_eq("end_stall", 32'(bus.cpu_stall), 32'd0);
        check_eq("end_we", 32'(bus.mem_we), 32'd0);
        check_eq("end_writes", 32'(we_count - base_we), 32'(n));
      end
    end
  endtask

  task automatic bad_start(input int n);
    int base_we;
    base_we = we_count;
    bus.start = 1'b1;
    bus.num_words = CNT_W'(n);
    tick();
    bus.start = 1'b0;
    check_eq("len_err", 32'(bus.err), 32'd1);
    check_eq("len_done", 32'(bus.done), 32'd0);
    check_eq("len_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    check_eq("len_busy_later", 32'(bus.busy), 32'd0);
    check_eq("len_no_write", 32'(we_count - base_we), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_flags"},
             32'({bus.mem_we, bus.in_ready, bus.cpu_stall, bus.busy, bus.done, bus.err}), 32'd0);
    check_eq({tag, "_addr"}, bus.mem_addr, 32'h0);
    check_eq({tag, "_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  initial begin
    int n;
    int ab;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 32'h0;
      seen_mem[i]  = 32'h0;
    end
    bus.start = 1'b0;
    bus.num_words = CNT_W'(0);
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) tick();
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Two-word load from the fixed program
    stim[0] = 8'h13; stim[1] = 8'h00; stim[2] = 8'h50; stim[3] = 8'h00;
    stim[4] = 8'h93; stim[5] = 8'h00; stim[6] = 8'hA0; stim[7] = 8'h00;
    do_load(2, -1, 1'b0, -1);
    check_eq("prog_word0", seen_mem[0], 32'h0050_0013);
    check_eq("prog_word1", seen_mem[1], 32'h00A0_0093);

    // Gapped single word
    stim[0] = 8'hEF; stim[1] = 8'hBE; stim[2] = 8'hAD; stim[3] = 8'hDE;
    do_load(1, -1, 1'b1, -1);
    check_eq("gapped_word", seen_mem[0], 32'hDEAD_BEEF);

    bad_start(0);
    bad_start(65);
    bad_start(127);

    // Abort after six bytes, then a clean reload at address 0
    for (int i = 0; i < 12; i++) stim[i] = 8'($urandom);
    do_load(3, 6, 1'b0, -1);
    for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
    do_load(1, -1, 1'b0, -1);

    // Full depth with a second start mid-load
    for (int i = 0; i < DEPTH * 4; i++) stim[i] = 8'($urandom);
    do_load(64, -1, 1'b0, 10);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("idle_abort_done", 32'(bus.done), 32'd1);
    check_eq("idle_abort_busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of the second word
    for (int i = 0; i < 8; i++) stim[i] = 8'($urandom);
    bus.start = 1'b1;
    bus.num_words = CNT_W'(2);
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) send_byte(stim[k], 1'b0);
    check_eq("pre_reset_we", 32'(bus.mem_we), 32'd1);
    model_mem[0] = le_word(0);
    send_byte(stim[4], 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_reset_outputs("post_reset");

    // Start and abort together in IDLE: the load must begin
    for (int i = 0; i < 8; i++) stim[i] = 8'($urandom);
    bus.abort = 1'b1;
    do_load(2, -1, 1'b0, -1);

    for (int t = 0; t < 12; t++) begin
      n = int'($urandom_range(1, 6));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4 * n)) : -1;
      for (int i = 0; i < 4 * n; i++) stim[i] = 8'($urandom);
      do_load(n, ab, 1'($urandom), -1);
    end

    for (int i = 0; i < DEPTH; i++) check_eq("image", seen_mem[i], model_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
